// File: rtl/xgmii_64b66b_encoder_if.sv
// XGMII-to-PCS encoder bus: input word (valid/data/control) and the encoded 66-bit block.
// The master drives the XGMII word; the slave (the encoder) returns the block.
interface xgmii_64b66b_encoder_if;
   logic        i_valid;
   logic [63:0] i_txd;
   logic [7:0]  i_txc;
   logic [65:0] o_block;
   logic        o_valid;

   modport master (
      output i_valid,
      output i_txd,
      output i_txc,
      input  o_block,
      input  o_valid
   );

   modport slave (
      input  i_valid,
      input  i_txd,
      input  i_txc,
      output o_block,
      output o_valid
   );
endinterface

// File: rtl/xgmii_64b66b_encoder.sv
// XGMII 64-bit data / 8-bit control to 64b/66b block encoder with transmit state machine.
// Illegal sequences are replaced by error blocks; saturating error and packet counters.
// Optional macro SCRAMBLER_EN enables the x^58+x^39+1 self-synchronous payload scrambler.
module xgmii_64b66b_encoder #(
   parameter int unsigned ERR_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 i_rst_n,
   xgmii_64b66b_encoder_if.slave bus_io,
   output logic [ERR_CNT_W-1:0] o_err_cnt,
   output logic [ERR_CNT_W-1:0] o_pkt_cnt
);

   typedef enum logic [1:0] {StInit, StC, StD, StE} tx_state_e;
   typedef enum logic [2:0] {ClsC, ClsS, ClsD, ClsT, ClsE} cls_e;

   localparam logic [7:0] CharIdle  = 8'h07;
   localparam logic [7:0] CharError = 8'hFE;
   localparam logic [7:0] CharStart = 8'hFB;
   localparam logic [7:0] CharTerm  = 8'hFD;

   localparam logic [63:0] EBlock = {7'h1E, 7'h1E, 7'h1E, 7'h1E,
                                     7'h1E, 7'h1E, 7'h1E, 7'h1E, 8'h1E};

   logic        valid;
   logic [63:0] txd;
   logic [7:0]  txc;

   assign valid = bus_io.i_valid;
   assign txd   = bus_io.i_txd;
   assign txc   = bus_io.i_txc;

   tx_state_e tx_state_q, tx_state_d;
   cls_e      cls;
   cls_e      emit;
   logic [2:0] t_lane;

   logic [63:0] payload;
   logic [63:0] payload_tx;
   logic [1:0]  sync;

   logic [65:0]          block_q, block_d;
   logic                 valid_q;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [ERR_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

   // Classify the incoming word as C, S, D, Tk or E.
   always_comb begin
      logic       ctl_ok;
      logic       is_t;
      logic       tail_ok;
      logic [7:0] t_mask;
      ctl_ok = 1'b1;
      is_t   = 1'b0;
      t_lane = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (txd[8*i +: 8] != CharIdle && txd[8*i +: 8] != CharError) begin
            ctl_ok = 1'b0;
         end
      end
      // Tk: data lanes below k, FD at k, idles above k.
      for (int k = 0; k < 8; k++) begin
         t_mask  = 8'hFF << k;
         tail_ok = 1'b1;
         for (int j = k + 1; j < 8; j++) begin
            if (txd[8*j +: 8] != CharIdle) begin
               tail_ok = 1'b0;
            end
         end
         if (txc == t_mask && txd[8*k +: 8] == CharTerm && tail_ok) begin
            is_t   = 1'b1;
            t_lane = 3'(k);
         end
      end
      if (txc == 8'hFF && ctl_ok) begin
         cls = ClsC;
      end else if (txc == 8'h01 && txd[7:0] == CharStart) begin
         cls = ClsS;
      end else if (txc == 8'h00) begin
         cls = ClsD;
      end else if (is_t) begin
         cls = ClsT;
      end else begin
         cls = ClsE;
      end
   end

   // Transmit state register; advances only on valid words.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         tx_state_q <= StInit;
      end else begin
         tx_state_q <= tx_state_d;
      end
   end

   // Next transmit state from current state and input class.
   always_comb begin
      tx_state_d = tx_state_q;
      if (valid) begin
         unique case (tx_state_q)
            StInit, StC: begin
               if (cls == ClsC) begin
                  tx_state_d = StC;
               end else if (cls == ClsS) begin
                  tx_state_d = StD;
               end else begin
                  tx_state_d = StE;
               end
            end
            StD: begin
               if (cls == ClsD) begin
                  tx_state_d = StD;
               end else if (cls == ClsT) begin
                  tx_state_d = StC;
               end else begin
                  tx_state_d = StE;
               end
            end
            StE: begin
               unique case (cls)
                  ClsC, ClsT: tx_state_d = StC;
                  ClsS, ClsD: tx_state_d = StD;
                  default:    tx_state_d = StE;
               endcase
            end
            default: tx_state_d = StE;
         endcase
      end
   end

   // Block type to emit: the input class if legal in this state, otherwise an error block.
   always_comb begin
      emit = ClsE;
      unique case (tx_state_q)
         StInit, StC: emit = (cls == ClsC || cls == ClsS) ? cls : ClsE;
         StD:         emit = (cls == ClsD || cls == ClsT) ? cls : ClsE;
         default:     emit = cls;
      endcase
   end

   // Build sync header and unscrambled payload for the emitted block type.
   always_comb begin
      payload = '0;
      sync    = 2'b01;
      unique case (emit)
         ClsD: begin
            payload = txd;
            sync    = 2'b10;
         end
         ClsC: begin
            payload[7:0] = 8'h1E;
            for (int i = 0; i < 8; i++) begin
               payload[8 + 7*i +: 7] = (txd[8*i +: 8] == CharError) ? 7'h1E : 7'h00;
            end
         end
         ClsS: begin
            payload = {txd[63:8], 8'h78};
         end
         ClsT: begin
            unique case (t_lane)
               3'd0:    payload[7:0] = 8'h87;
               3'd1:    payload[7:0] = 8'h99;
               3'd2:    payload[7:0] = 8'hAA;
               3'd3:    payload[7:0] = 8'hB4;
               3'd4:    payload[7:0] = 8'hCC;
               3'd5:    payload[7:0] = 8'hD2;
               3'd6:    payload[7:0] = 8'hE1;
               default: payload[7:0] = 8'hFF;
            endcase
            // Pad bits and idle codes after the data lanes are all zero.
            for (int j = 0; j < 7; j++) begin
               if (j < int'(t_lane)) begin
                  payload[8 + 8*j +: 8] = txd[8*j +: 8];
               end
            end
         end
         default: begin
            payload = EBlock;
         end
      endcase
   end

`ifdef SCRAMBLER_EN
   logic [57:0] scr_q, scr_d;

   // Serial scramble from payload bit 0 upward; feedback uses scrambled bits.
   always_comb begin
      logic [57:0] s;
      s          = scr_q;
      payload_tx = '0;
      for (int b = 0; b < 64; b++) begin
         payload_tx[b] = payload[b] ^ s[38] ^ s[57];
         s             = {s[56:0], payload_tx[b]};
      end
      scr_d = s;
   end

   // Scrambler state; holds while the input is not valid.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         scr_q <= '1;
      end else if (valid) begin
         scr_q <= scr_d;
      end
   end
`else
   assign payload_tx = payload;
`endif

   assign block_d = {payload_tx, sync};

   // Saturating counters for error and terminate blocks.
   always_comb begin
      err_cnt_d = err_cnt_q;
      pkt_cnt_d = pkt_cnt_q;
      if (valid && emit == ClsE && err_cnt_q != '1) begin
         err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
      if (valid && emit == ClsT && pkt_cnt_q != '1) begin
         pkt_cnt_d = pkt_cnt_q + ERR_CNT_W'(1);
      end
   end

   // Output block, valid and counters; block holds while input is not valid.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         block_q   <= '0;
         valid_q   <= 1'b0;
         err_cnt_q <= '0;
         pkt_cnt_q <= '0;
      end else begin
         valid_q   <= valid;
         err_cnt_q <= err_cnt_d;
         pkt_cnt_q <= pkt_cnt_d;
         if (valid) begin
            block_q <= block_d;
         end
      end
   end

   assign bus_io.o_block = block_q;
   assign bus_io.o_valid = valid_q;
   assign o_err_cnt      = err_cnt_q;
   assign o_pkt_cnt      = pkt_cnt_q;

endmodule
